imm_gen_pipe: RTL and testbench

Parametrised, buffered successor to the combinational immediate generator. Decodes every RV32/RV64 base immediate format (I, S, B, U, J, shift amount, optional CSR zimm) from a fetched instruction word, sign/zero-extends it to XLEN, and queues the result with a caller tag in a small FIFO. Sits between fetch and decode/execute of the pipelined core, with valid/ready handshakes on both sides and a flush for branch redirects.

---
 rtl/imm_gen_pipe.sv | 122 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate decoder feeding a small tagged FIFO with valid/ready on both sides.
// Build option: define IMM_GEN_ZIMM_EN to make format 110 (CSR zimm) legal; otherwise it decodes as illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 imm_src,
  input  logic [31:0]                inst_code,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            imm_out,
  output logic                       imm_err,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH)+1-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Returns {err, imm}. Formats are first built as a signed 32-bit value so a
  // single signed widening handles both XLEN=32 and XLEN=64.
  function automatic logic [XLEN:0] decode_imm(input logic [2:0] src, input logic [31:0] inst);
    logic signed [31:0]     raw;
    logic signed [XLEN-1:0] ext;
    logic                   err;
    raw = '0;
    err = 1'b0;
    case (src)
      3'b000: raw = {{20{inst[31]}}, inst[31:20]};
      3'b001: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'b010: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'b011: raw = {inst[31:12], 12'b0};
      3'b100: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'b101: raw = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
`ifdef IMM_GEN_ZIMM_EN
      3'b110: raw = {27'b0, inst[19:15]};
`else
      3'b110: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
    ext = XLEN'(raw);
    return {err, ext};
  endfunction

  logic signed [XLEN-1:0] imm_p0;
  logic                   err_p0;
  logic                   vld_p0;
  logic                   vld_p1;
  logic                   push;
  logic                   pop;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic             mem_err [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  // Stage p0: combinational decode of the offered instruction
  always_comb begin
    {err_p0, imm_p0} = decode_imm(imm_src, inst_code);
  end

  assign vld_p0   = in_valid;
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = vld_p0 && in_ready;
  assign vld_p1   = (count_q != '0);
  assign pop      = vld_p1 && out_ready;

  // Stage p1: FIFO control; flush outranks any push or pop in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is never reset; an empty FIFO masks it at the outputs.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_imm[wr_ptr] <= imm_p0;
      mem_err[wr_ptr] <= err_p0;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_comb begin
    imm_out = '0;
    imm_err = 1'b0;
    out_tag = '0;
    if (vld_p1) begin
      imm_out = mem_imm[rd_ptr];
      imm_err = mem_err[rd_ptr];
      out_tag = mem_tag[rd_ptr];
    end
  end

  assign out_valid = vld_p1;
  assign count     = count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready, in_ready64;
  logic [2:0]  imm_src;
  logic [31:0] inst_code;
  logic [3:0]  in_tag;
  logic        out_valid, out_valid64;
  logic        out_ready;
  logic [31:0] imm_out;
  logic [63:0] imm_out64;
  logic        imm_err, imm_err64;
  logic [3:0]  out_tag, out_tag64;
  logic [1:0]  count, count64;

  int checks = 0;
  int fails  = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .imm_out(imm_out), .imm_err(imm_err), .out_tag(out_tag), .count(count));

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(4)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .imm_src(imm_src), .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_out(imm_out64), .imm_err(imm_err64), .out_tag(out_tag64), .count(count64));

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive_push(input logic [2:0] src, input logic [31:0] inst, input logic [3:0] tag);
    imm_src = src; inst_code = inst; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = 3'b000; inst_code = '0; in_tag = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (imm_out !== 32'h0) begin fails++; $display("FAIL reset_imm got=%h want=0", imm_out); end
    checks++; if (imm_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", imm_err); end
    checks++; if (out_tag !== 4'h0) begin fails++; $display("FAIL reset_tag got=%h want=0", out_tag); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_i_s();
    drive_push(3'b000, 32'hFFF00093, 4'd1);
    checks++; if (count !== 2'd1) begin fails++; $display("FAIL i_count got=%0d want=1", count); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL i_valid got=%b want=1", out_valid); end
    checks++; if (imm_out !== 32'hFFFFFFFF) begin fails++; $display("FAIL i_imm got=%h want=ffffffff", imm_out); end
    checks++; if (imm_out64 !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL i_imm64 got=%h want=ffffffffffffffff", imm_out64); end
    checks++; if (out_tag !== 4'd1) begin fails++; $display("FAIL i_tag got=%0d want=1", out_tag); end
    drive_push(3'b001, 32'hFE20AE23, 4'd2);
    checks++; if (imm_out !== 32'hFFFFFFFF) begin fails++; $display("FAIL i_head_stable got=%h want=ffffffff", imm_out); end
    do_pop();
    checks++; if (imm_out !== 32'hFFFFFFFC) begin fails++; $display("FAIL s_imm got=%h want=fffffffc", imm_out); end
    checks++; if (imm_err !== 1'b0) begin fails++; $display("FAIL s_err got=%b want=0", imm_err); end
    checks++; if (out_tag !== 4'd2) begin fails++; $display("FAIL s_tag got=%0d want=2", out_tag); end
    do_pop();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_valid got=%b want=0", out_valid); end
    checks++; if (imm_out !== 32'h0) begin fails++; $display("FAIL empty_imm got=%h want=0", imm_out); end
  endtask

  task automatic test_b_u_j();
    logic [2:0]  src_t [5] = '{3'b010, 3'b011, 3'b100, 3'b011, 3'b101};
    logic [31:0] ins_t [5] = '{32'h00000463, 32'h123450B7, 32'hFFDFF06F, 32'h800000B7, 32'h03F0D093};
    logic [31:0] e32_t [5] = '{32'h8, 32'h12345000, 32'hFFFFFFFC, 32'h80000000, 32'h1F};
    logic [63:0] e64_t [5] = '{64'h8, 64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h3F};
    for (int i = 0; i < 5; i++) begin
      drive_push(src_t[i], ins_t[i], 4'(i));
      checks++; if (imm_out !== e32_t[i]) begin fails++; $display("FAIL fmt%0d_imm got=%h want=%h", i, imm_out, e32_t[i]); end
      checks++; if (imm_out64 !== e64_t[i]) begin fails++; $display("FAIL fmt%0d_imm64 got=%h want=%h", i, imm_out64, e64_t[i]); end
      checks++; if (imm_err !== 1'b0) begin fails++; $display("FAIL fmt%0d_err got=%b want=0", i, imm_err); end
      do_pop();
    end
  endtask

  task automatic test_illegal_zimm();
    logic [31:0] zexp;
    logic        zerr;
`ifdef IMM_GEN_ZIMM_EN
    zexp = 32'h0000000F; zerr = 1'b0;
`else
    zexp = 32'h0; zerr = 1'b1;
`endif
    drive_push(3'b111, 32'hFFFFFFFF, 4'd7);
    checks++; if (imm_out !== 32'h0) begin fails++; $display("FAIL illegal_imm got=%h want=0", imm_out); end
    checks++; if (imm_err !== 1'b1) begin fails++; $display("FAIL illegal_err got=%b want=1", imm_err); end
    checks++; if (imm_err64 !== 1'b1) begin fails++; $display("FAIL illegal_err64 got=%b want=1", imm_err64); end
    do_pop();
    drive_push(3'b110, 32'h0007D073, 4'd8);
    checks++; if (imm_out !== zexp) begin fails++; $display("FAIL zimm_imm got=%h want=%h", imm_out, zexp); end
    checks++; if (imm_err !== zerr) begin fails++; $display("FAIL zimm_err got=%b want=%b", imm_err, zerr); end
    do_pop();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; imm_src = 3'b000; inst_code = 32'h00100093;
    in_tag = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_first count=%0d rdy=%b want 1/1", count, in_ready); end
    in_tag = 4'd1;
    @(posedge clk); #1;
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_full count=%0d rdy=%b want 2/0", count, in_ready); end
    in_tag = 4'd2;
    @(posedge clk); #1;
    checks++; if (count !== 2'd2 || out_tag !== 4'd0) begin fails++; $display("FAIL bp_blocked count=%0d tag=%0d want 2/0", count, out_tag); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || count !== 2'd1) begin fails++; $display("FAIL bp_reready rdy=%b count=%0d want 1/1", in_ready, count); end
    checks++; if (out_tag !== 4'd1) begin fails++; $display("FAIL bp_order1 got=%0d want=1", out_tag); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_tag !== 4'd2 || count !== 2'd1) begin fails++; $display("FAIL bp_order2 tag=%0d count=%0d want 2/1", out_tag, count); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained count=%0d valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_back_to_back_flush();
    drive_push(3'b000, 32'h00500093, 4'd5);
    in_tag = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 2'd1) begin fails++; $display("FAIL pushpop_count got=%0d want=1", count); end
    checks++; if (out_tag !== 4'd6 || imm_out !== 32'h5) begin fails++; $display("FAIL pushpop_head tag=%0d imm=%h want 6/5", out_tag, imm_out); end
    flush = 1'b1; in_tag = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 2'd0) begin fails++; $display("FAIL flush_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0 || out_tag !== 4'd0) begin fails++; $display("FAIL flush_head valid=%b tag=%0d want 0/0", out_valid, out_tag); end
    drive_push(3'b000, 32'h00900093, 4'd9);
    checks++; if (out_tag !== 4'd9 || count !== 2'd1) begin fails++; $display("FAIL postflush tag=%0d count=%0d want 9/1", out_tag, count); end
    do_pop();
  endtask

  task automatic test_reset_midstream();
    drive_push(3'b000, 32'h00300093, 4'd3);
    drive_push(3'b000, 32'h00400093, 4'd4);
    checks++; if (count !== 2'd2) begin fails++; $display("FAIL mid_pre_count got=%0d want=2", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin fails++; $display("FAIL mid_async valid=%b count=%0d want 0/0", out_valid, count); end
    checks++; if (in_ready !== 1'b1 || imm_out !== 32'h0) begin fails++; $display("FAIL mid_async rdy=%b imm=%h want 1/0", in_ready, imm_out); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || count64 !== 2'd0) begin fails++; $display("FAIL mid_after valid=%b count64=%0d want 0/0", out_valid, count64); end
  endtask

  initial begin
    test_reset();
    test_i_s();
    test_b_u_j();
    test_illegal_zimm();
    test_backpressure();
    test_back_to_back_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule
